ps2kbd: RTL and testbench
=========================

# ps2kbd

PS/2 keyboard receiver for the I/O bus. It samples `ps2kbd_clk`/`ps2kbd_data` and deframes 11-bit device-to-host frames. Valid scan-code bytes go into a FIFO, and the block exposes data, status and control registers as a Wishbone slave on a free `mmu_bus2` port (p4). It raises a level interrupt toward `interrupt_encoder` while data is pending.

## Interface
- `CLKFREQ`, 10000000: `clk_i` frequency in Hz.
- `TIMEOUT`, CLKFREQ/5000: idle `clk_i` cycles mid-frame before the frame is abandoned (200 µs at default).
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `bus`  if_wb.slave  —  Wishbone slave.
  - Uses `cyc`, `stb`, `we`, `adr[3:2]`, `dat_i[31:0]` and `sel`.
  - Returns `dat_o[31:0]` and `ack`.
- `ps2_clk`  in  1  raw PS/2 clock (asynchronous).
- `ps2_data`  in  1  raw PS/2 data (asynchronous).
- `interrupt`  out  1  `int_en & ~empty`.

## Operation
- **Input synchronization:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A third `ps2_clk` stage forms the falling-edge strobe `fall` = prev 1, now 0. Data is sampled on `fall`.
- **Receiver FSM:**
  - IDLE: on `fall` with data 0 → SHIFT, bitcnt=0. On `fall` with data 1, stay in IDLE (spurious edge ignored).
  - SHIFT: each `fall` shifts data in LSB first, bitcnt++. After the 8th bit → PARITY.
  - PARITY: on `fall`, latch the parity bit → STOP.
  - STOP: on `fall`:
    - data 1 and odd parity correct (XOR of 8 data bits and parity bit = 1) → push the byte, IDLE.
    - parity wrong → set `parity_err`, no push, IDLE.
    - stop bit 0 → set `frame_err`, no push, IDLE.
- **Timeout:** a 16-bit idle counter clears on every `fall` and increments in any state other than IDLE. When it reaches `TIMEOUT` → IDLE, set `timeout_err`, no push.
- **FIFO:**
  - DEPTH entries with wrapping read/write pointers and `count` of 0..DEPTH.
  - Push when full → byte dropped, `overrun` set.
  - Push and pop in the same cycle: when full, both are accepted, count unchanged and no overrun. When empty, the pop is a no-op and the push lands.
- **Registers (byte address offset):**
  - 0x0 DATA (R): [7:0] FIFO head, [8] valid (=~empty at the access), [31:9] 0. A read pops if non-empty. Writes are ignored and acked.
  - 0x4 STATUS (R/W1C): [0] empty, [1] full, [6:2] count, [8] parity_err, [9] frame_err, [10] overrun, [11] timeout_err, other bits 0. Writing 1 to a bit in [11:8] clears it. If an error sets in the same cycle as its W1C, it stays set.
  - 0x8 CONTROL (R/W): [0] int_en, other bits read 0.
  - 0xC: reads 0, writes ignored.
- `sel` is ignored; all accesses are full-word.

## Timing
- **Wishbone handshake:** `ack` is high in the cycle after the cycle where `cyc & stb & ~ack`. It is a one-cycle pulse, so a held request gets one ack every 2 cycles.
- `dat_o` is registered and valid while `ack` is high.
- **Access side effects** (DATA pop, register write, W1C) happen at the clock edge that raises `ack`.
- **Push latency:** the byte is visible in STATUS.count 1 cycle after the 11th `fall` strobe. `fall` itself lags the pin by 3 `clk_i` cycles.
- `interrupt` is combinational from registered state. It drops in the cycle after the popping ack when the FIFO empties.
- **Reset** (`rst_i` = 0 at an edge):
  - FSM → IDLE, bitcnt and idle counter 0.
  - FIFO pointers and count 0.
  - All error flags 0, `int_en` 0, `ack` 0, `dat_o` 0, `interrupt` 0.
  - Synchronizers load 1.
  - A frame in progress at reset is discarded. Reset while `ack` is pending drops the ack.

## Test plan
- **Good frame:** send 0x1C (parity 0, stop 1) at 12.5 kHz → STATUS=0x0000_0004 (count 1), `interrupt`=0. Set CONTROL=1 → `interrupt`=1. Read DATA → 0x11C. Next STATUS=0x1, `interrupt`=0.
- **Parity error:** send 0x1C with parity 1 → no push, STATUS[8]=1. Write STATUS=0x100 → bit clears.
- **Overrun:** send 9 frames 0x01..0x09 with no reads → count 8, full=1, overrun=1. DATA reads return 0x101..0x108, then 0x000 (valid 0, no pointer change).
- **Timeout:** send start plus 4 bits, then hold `ps2_clk` high for 2000 cycles → timeout_err=1, FSM back in IDLE. A following good frame 0x5A is received correctly.
- **Boundary and reset:**
  - With the FIFO full, the DATA read ack coincides with a push → count stays 8 and no overrun.
  - Assert `rst_i`=0 mid-frame → all registers read reset values, and the next frame 0xF0 is received.

Source files
------------

// File: rtl/ps2kbd.sv
// rtl/ps2kbd.sv - PS/2 keyboard receiver with scan-code FIFO and Wishbone register slave
module ps2kbd #(
  parameter int CLKFREQ = 10000000,
  parameter int TIMEOUT = CLKFREQ / 5000,
  parameter int DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_cyc,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [3:2]  bus_adr,
  input  logic [31:0] bus_dat_i,
  input  logic [3:0]  bus_sel,
  output logic [31:0] bus_dat_o,
  output logic        bus_ack,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        interrupt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C   = 5'(DEPTH);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic c1, c2, c3, d1, d2, fall;
  logic [1:0]  state;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [15:0] idle_cnt;
  logic        push, perr_set, ferr_set, terr_set;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          empty, full, do_push, do_pop, ovr_set;

  logic parity_err, frame_err, overrun, timeout_err, int_en;
  logic req, wr_status, wr_ctrl;
  logic [31:0] data_word, status_word, rd_word;
  logic unused;

  assign unused = ^{bus_sel, bus_dat_i[31:12], bus_dat_i[7:1]};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      {c1, c2, c3, d1, d2} <= '1;
    end else begin
      c1 <= ps2_clk;
      c2 <= c1;
      c3 <= c2;
      d1 <= ps2_data;
      d2 <= d1;
    end
  end

  assign fall = c3 & ~c2;

  // Frame outcome is decided combinationally so the push lands on the 11th fall edge.
  always_comb begin
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    terr_set = 1'b0;
    if (state == STOP && fall) begin
      if (!d2)                   ferr_set = 1'b1;
      else if (^{shreg, par_bit}) push    = 1'b1;
      else                       perr_set = 1'b1;
    end
    if (state != IDLE && !fall && idle_cnt == TIMEOUT_C) terr_set = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      case (state)
        IDLE: if (!d2) begin
          state  <= SHIFT;
          bitcnt <= '0;
        end
        SHIFT: begin
          shreg  <= {d2, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          par_bit <= d2;
          state   <= STOP;
        end
        default: state <= IDLE;
      endcase
    end else if (terr_set) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else if (state != IDLE) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign req       = bus_cyc & bus_stb & ~bus_ack;
  assign wr_status = req & bus_we & (bus_adr == 2'b01);
  assign wr_ctrl   = req & bus_we & (bus_adr == 2'b10);
  assign empty     = (count == 5'd0);
  assign full      = (count == DEPTH_C);
  assign do_pop    = req & ~bus_we & (bus_adr == 2'b00) & ~empty;
  // A pop frees a slot in the same edge, so a push into a full FIFO is still accepted.
  assign do_push   = push & (~full | do_pop);
  assign ovr_set   = push & full & ~do_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + 5'd1;
      else if (do_pop && !do_push) count <= count - 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      int_en      <= 1'b0;
    end else begin
      parity_err  <= (parity_err  & ~(wr_status & bus_dat_i[8]))  | perr_set;
      frame_err   <= (frame_err   & ~(wr_status & bus_dat_i[9]))  | ferr_set;
      overrun     <= (overrun     & ~(wr_status & bus_dat_i[10])) | ovr_set;
      timeout_err <= (timeout_err & ~(wr_status & bus_dat_i[11])) | terr_set;
      if (wr_ctrl) int_en <= bus_dat_i[0];
    end
  end

  assign data_word   = empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
  assign status_word = {20'd0, timeout_err, overrun, frame_err, parity_err, 1'b0, count, full, empty};

  always_comb begin
    rd_word = 32'd0;
    case (bus_adr)
      2'b00:   rd_word = data_word;
      2'b01:   rd_word = status_word;
      2'b10:   rd_word = {31'd0, int_en};
      default: rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus_ack   <= 1'b0;
      bus_dat_o <= '0;
    end else begin
      bus_ack <= req;
      if (req) bus_dat_o <= rd_word;
    end
  end

  assign interrupt = int_en & ~empty;
endmodule

// File: tb/tb_ps2kbd.sv
// tb/tb_ps2kbd.sv - randomized scoreboard bench for the PS/2 keyboard receiver
`timescale 1ns/1ps
module tb_ps2kbd;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        bus_cyc, bus_stb, bus_we;
  logic [3:2]  bus_adr;
  logic [31:0] bus_dat_i;
  logic [3:0]  bus_sel;
  logic [31:0] bus_dat_o;
  logic        bus_ack;
  logic        ps2_clk, ps2_data;
  logic        interrupt;

  ps2kbd dut (
    .clk_i(clk), .rst_i(rst_i), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_adr(bus_adr), .bus_dat_i(bus_dat_i), .bus_sel(bus_sel), .bus_dat_o(bus_dat_o),
    .bus_ack(bus_ack), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    bit          chk;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  bit m_perr, m_ferr, m_ovr, m_terr, m_inten;

  function void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function logic [31:0] m_status();
    return {20'd0, m_terr, m_ovr, m_ferr, m_perr, 1'b0, 5'(mq.size()),
            mq.size() == 8, mq.size() == 0};
  endfunction

  function logic [31:0] m_data();
    logic [7:0] b;
    if (mq.size() == 0) return 32'd0;
    b = mq.pop_front();
    return {23'd0, 1'b1, b};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_i && bus_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check(e.name, bus_dat_o, e.val);
      end
    end
  end

  task automatic bus_cycle(input logic we, input logic [1:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = we; bus_adr = a; bus_dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_ack && n < 10);
    check("ack_arrives", {31'd0, bus_ack}, 32'd1);
    bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string nm);
    exp_t e;
    case (a)
      2'd0:    e.val = m_data();
      2'd1:    e.val = m_status();
      2'd2:    e.val = {31'd0, m_inten};
      default: e.val = 32'd0;
    endcase
    e.chk = 1'b1; e.name = nm;
    exp_q.push_back(e);
    bus_cycle(1'b0, a, 32'd0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    if (a == 2'd1) begin
      if (d[8])  m_perr = 1'b0;
      if (d[9])  m_ferr = 1'b0;
      if (d[10]) m_ovr  = 1'b0;
      if (d[11]) m_terr = 1'b0;
    end else if (a == 2'd2) begin
      m_inten = d[0];
    end
    e.val = 32'd0; e.chk = 1'b0; e.name = "write";
    exp_q.push_back(e);
    bus_cycle(1'b1, a, d);
  endtask

  task automatic chk_int(input string nm);
    @(negedge clk);
    check(nm, {31'd0, interrupt}, {31'd0, m_inten && mq.size() > 0});
  endtask

  // Optionally lines a DATA read ack up with the edge that pushes this frame's byte.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit coincide);
    logic [10:0] bits;
    exp_t e;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && coincide) begin
        @(negedge clk);
        @(negedge clk);
        e.val = m_data(); e.chk = 1'b1; e.name = "coincide_data";
        exp_q.push_back(e);
        bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = 1'b0; bus_adr = 2'd0;
        @(negedge clk);
        check("coincide_ack", {31'd0, bus_ack}, 32'd1);
        bus_cyc = 1'b0; bus_stb = 1'b0;
        repeat (half - 3) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (half) @(negedge clk);
    if (bad_stop)           m_ferr = 1'b1;
    else if (bad_par)       m_perr = 1'b1;
    else if (mq.size() == 8) m_ovr = 1'b1;
    else                    mq.push_back(b);
  endtask

  task automatic send_partial(input int nbits, input int half);
    for (int i = 0; i <= nbits; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_adr = 2'd0;
    bus_dat_i = 32'd0; bus_sel = 4'hF; ps2_clk = 1'b1; ps2_data = 1'b1;
    m_perr = 0; m_ferr = 0; m_ovr = 0; m_terr = 0; m_inten = 0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, bus_ack}, 32'd0);
    check("rst_dat_o", bus_dat_o, 32'd0);
    check("rst_int", {31'd0, interrupt}, 32'd0);
    rst_i = 1'b1;
    bus_read(2'd1, "status_reset");
    bus_read(2'd2, "control_reset");

    send_frame(8'h1C, 0, 0, 400, 0);
    bus_read(2'd1, "status_one");
    chk_int("int_disabled");
    bus_write(2'd2, 32'd1);
    chk_int("int_enabled");
    bus_read(2'd0, "data_1c");
    chk_int("int_dropped");
    bus_read(2'd1, "status_empty");

    send_frame(8'h1C, 1, 0, 30, 0);
    bus_read(2'd1, "status_parity");
    bus_write(2'd1, 32'h100);
    bus_read(2'd1, "status_parity_clr");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 25, 0);
    bus_read(2'd1, "status_overrun");
    for (int i = 0; i < 9; i++) bus_read(2'd0, "data_overrun");
    bus_read(2'd1, "status_drained");
    bus_write(2'd1, 32'hF00);

    send_partial(4, 30);
    repeat (2500) @(negedge clk);
    m_terr = 1'b1;
    bus_read(2'd1, "status_timeout");
    send_frame(8'h5A, 0, 0, 30, 0);
    bus_read(2'd0, "data_5a");
    bus_write(2'd1, 32'hF00);

    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 0, 0, 25, 0);
    send_frame(8'($urandom), 0, 0, 25, 1);
    bus_read(2'd1, "status_coincide");
    for (int i = 0; i < 8; i++) bus_read(2'd0, "data_coincide");
    chk_int("int_after_drain");

    for (int i = 0; i < 12; i++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      send_frame(8'($urandom), kind == 0, kind == 1, int'($urandom_range(15, 40)), 0);
      if ($urandom_range(0, 2) == 0) bus_read(2'd0, "data_rnd");
      if ($urandom_range(0, 3) == 0) bus_read(2'd1, "status_rnd");
    end
    bus_read(2'd1, "status_rnd_end");
    chk_int("int_rnd");
    while (mq.size() > 0) bus_read(2'd0, "data_rnd_drain");
    bus_read(2'd0, "data_rnd_empty");
    bus_write(2'd1, 32'hF00);

    bus_write(2'd2, 32'd1);
    send_frame(8'h33, 0, 0, 25, 0);
    send_partial(3, 25);
    @(negedge clk);
    rst_i = 1'b0; bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = 1'b0; bus_adr = 2'd1;
    @(negedge clk);
    check("rst_drops_ack", {31'd0, bus_ack}, 32'd0);
    check("rst_int_mid", {31'd0, interrupt}, 32'd0);
    bus_cyc = 1'b0; bus_stb = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    mq.delete();
    m_perr = 0; m_ferr = 0; m_ovr = 0; m_terr = 0; m_inten = 0;
    bus_read(2'd1, "status_after_rst");
    bus_read(2'd2, "control_after_rst");
    bus_read(2'd0, "data_after_rst");
    bus_read(2'd3, "reg_c");
    send_frame(8'hF0, 0, 0, 25, 0);
    bus_read(2'd0, "data_f0");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
